// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide sequencer:
// funct3 op codes, FSM state encodings and datapath widths.
package alu_muldiv_seq_pkg;

  localparam int XLEN          = 32;
  localparam int CNT_W         = 5;
  localparam int MULDIV_OP_W   = 3;

  typedef enum logic [MULDIV_OP_W-1:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_muldiv_seq_step.sv
// One iteration of the sequencer datapath: shift-add multiply (mode=0)
// or restoring trial-subtract divide (mode=1). Purely combinational.
module alu_muldiv_seq_step #(
  parameter int XLEN = 32
) (
  input  logic                mode,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     opa,
  input  logic [XLEN-1:0]     opb,
  output logic [2*XLEN-1:0]   acc_next,
  output logic [XLEN-1:0]     opa_next,
  output logic [XLEN-1:0]     opb_next
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_diff;
  logic            rem_ge;

  always_comb begin
    // Multiply: add multiplicand into the high half, then shift the whole
    // accumulator right so the carry lands in the top bit.
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (opb[0] ? {1'b0, opa} : '0);
    // Divide: remainder lives in the high half, quotient shifts into the low
    // half, dividend bits are fed in from the top of opa.
    rem_sh   = {acc[2*XLEN-1:XLEN], opa[XLEN-1]};
    rem_ge   = (rem_sh >= {1'b0, opb});
    rem_diff = rem_sh[XLEN-1:0] - opb;

    if (mode) begin
      acc_next = {(rem_ge ? rem_diff : rem_sh[XLEN-1:0]), acc[XLEN-2:0], rem_ge};
      opa_next = {opa[XLEN-2:0], 1'b0};
      opb_next = opb;
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
      opa_next = opa;
      opb_next = {1'b0, opb[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer beside the execute-stage ALU.
// Handshake: an op is accepted on a rising edge with start=1, ready=1, flush=0; result is valid while done=1.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_step;
  logic [XLEN-1:0]   opa_q, opb_q, opa_step, opb_step;
  logic [2:0]        op_q;
  logic              neg1_q, neg2_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              s1_signed, s2_signed;
  logic              in_neg1, in_neg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val;
  logic [2*XLEN-1:0] acc_fix;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fix_val;

  // Operand decode on the incoming request, used only at accept.
  always_comb begin
    accept    = (state_q == ST_IDLE) && start && !flush;
    s1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    s2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    in_neg1   = s1_signed && src1[XLEN-1];
    in_neg2   = s2_signed && src2[XLEN-1];
    mag1      = in_neg1 ? -src1 : src1;
    mag2      = in_neg2 ? -src2 : src2;
    div_zero  = op[2] && (src2 == '0);
    div_ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    special   = div_zero || div_ovf;
    special_val = '0;
    if (div_zero)
      special_val = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : src1;
    else if (div_ovf)
      special_val = (op == OP_DIV) ? src1 : '0;
  end

  // Sign correction applied in FIX on the finished accumulator.
  always_comb begin
    acc_fix = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
    quo     = acc_q[XLEN-1:0];
    rem     = acc_q[2*XLEN-1:XLEN];
    fix_val = '0;
    case (op_q)
      OP_MUL:                     fix_val = acc_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = acc_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            fix_val = (neg1_q ^ neg2_q) ? -quo : quo;
      default:                    fix_val = neg1_q ? -rem : rem;
    endcase
  end

  alu_muldiv_seq_step #(.XLEN(XLEN)) u_muldiv_step (
    .mode     (op_q[2]),
    .acc      (acc_q),
    .opa      (opa_q),
    .opb      (opb_q),
    .acc_next (acc_step),
    .opa_next (opa_step),
    .opb_next (opb_step)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (flush)                             state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1))    state_d = ST_FIX;
      end
      ST_FIX:  state_d = flush ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= op;
      neg1_q <= in_neg1;
      neg2_q <= in_neg2;
      opa_q  <= mag1;
      opb_q  <= mag2;
      acc_q  <= '0;
      cnt_q  <= '0;
      if (special) result_q <= special_val;
    end else if (state_q == ST_CALC && !flush) begin
      acc_q <= acc_step;
      opa_q <= opa_step;
      opb_q <= opb_step;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == ST_FIX && !flush) begin
      result_q <= fix_val;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: scoreboard on done, per-feature
// timing checks counted in cycles after the accept edge.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic        clk, rst, start, flush;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        ready, busy, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  logic [31:0] last_res;
  int          n_cmp, n_err;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .src1(src1), .src2(src2), .ready(ready), .busy(busy), .done(done),
    .result(result), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: done=1 result=%h with no pending op", result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        last_res = e;
        if (result !== e) begin
          n_err++;
          $display("FAIL scoreboard_result: got %h expected %h", result, e);
        end
      end
    end
  end

  // driver: present one op and let the next edge accept it
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    @(negedge clk);
    op = o; src1 = a; src2 = b; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // observe cycles after accept: first done cycle, busy count, first ready cycle
  task automatic observe(input int limit, output int d, output int b, output int r);
    d = -1; b = 0; r = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (busy === 1'b1) b++;
      if (done === 1'b1 && d < 0) d = n;
      if (ready === 1'b1) begin
        r = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp += 5;
    if (ready !== 1'b1)      begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
    if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    if (result !== 32'h0)    begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
    if (dbg_state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b expected 00", dbg_state); end
  endtask

  task automatic test_mul_timing();
    int d, b, r;
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    observe(40, d, b, r);
    n_cmp += 3;
    if (d != 34) begin n_err++; $display("FAIL mul_done_cycle: got %0d expected 34", d); end
    if (b != 33) begin n_err++; $display("FAIL mul_busy_cycles: got %0d expected 33", b); end
    if (r != 35) begin n_err++; $display("FAIL mul_ready_cycle: got %0d expected 35", r); end
  endtask

  task automatic test_mul_high();
    logic [2:0]  ops [4] = '{OP_MULHU, OP_MULH, OP_MULHSU, OP_MUL};
    logic [31:0] exps[4] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h1};
    int d, b, r;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, exps[i]);
      observe(40, d, b, r);
      n_cmp++;
      if (d != 34) begin n_err++; $display("FAIL mulh_done_cycle[%0d]: got %0d expected 34", i, d); end
    end
    // random unsigned high products against a 64-bit reference
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, c;
      logic [63:0] p;
      a = $urandom_range(32'hFFFF_FFFF, 0);
      c = $urandom_range(32'hFFFF_FFFF, 0);
      p = {32'h0, a} * {32'h0, c};
      issue(OP_MULHU, a, c, p[63:32]);
      observe(40, d, b, r);
      n_cmp++;
      if (d != 34) begin n_err++; $display("FAIL mulhu_rand_done[%0d]: got %0d expected 34", i, d); end
    end
  endtask

  task automatic test_divide();
    logic [2:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] a_t [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b_t [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hE, 32'h2};
    int d, b, r;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], a_t[i], b_t[i], exps[i]);
      observe(40, d, b, r);
      n_cmp++;
      if (d != 34) begin n_err++; $display("FAIL div_done_cycle[%0d]: got %0d expected 34", i, d); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM};
    logic [31:0] a_t [4] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b_t [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};
    int d, b, r;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], a_t[i], b_t[i], exps[i]);
      observe(10, d, b, r);
      n_cmp += 3;
      if (d != 1) begin n_err++; $display("FAIL special_done[%0d]: got %0d expected 1", i, d); end
      if (b != 0) begin n_err++; $display("FAIL special_busy[%0d]: got %0d expected 0", i, b); end
      if (r != 2) begin n_err++; $display("FAIL special_ready[%0d]: got %0d expected 2", i, r); end
    end
  endtask

  task automatic test_flush();
    int d, b, r, extra;
    logic [31:0] held;
    held = last_res;
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd333);
    for (int n = 1; n <= 10; n++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    void'(exp_q.pop_back());
    observe(5, d, b, r);
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_cmp += 4;
    if (r != 1)          begin n_err++; $display("FAIL flush_ready: got %0d expected 1", r); end
    if (d != -1)         begin n_err++; $display("FAIL flush_done: got %0d expected -1", d); end
    if (extra != 0)      begin n_err++; $display("FAIL flush_late_done: got %0d expected 0", extra); end
    if (result !== held) begin n_err++; $display("FAIL flush_result: got %h expected %h", result, held); end
    // flush together with start in IDLE: no accept
    @(negedge clk);
    op = OP_MUL; src1 = 32'd2; src2 = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (ready !== 1'b1) begin n_err++; $display("FAIL flush_start_ready: got %b expected 1", ready); end
    if (busy !== 1'b0)  begin n_err++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int d, b, r, ndone, dcyc;
    logic rdy35, busy36;
    ndone = 0; dcyc = -1; rdy35 = 1'b0; busy36 = 1'b0;
    @(negedge clk);
    op = OP_MULHU; src1 = 32'hFFFF_FFFF; src2 = 32'd2; start = 1'b1;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) dcyc = n;
      end
      if (n == 35) rdy35 = ready;
      if (n == 36) busy36 = busy;
    end
    start = 1'b0;
    observe(40, d, b, r);
    n_cmp += 5;
    if (ndone != 1)      begin n_err++; $display("FAIL b2b_done_count: got %0d expected 1", ndone); end
    if (dcyc != 34)      begin n_err++; $display("FAIL b2b_done_cycle: got %0d expected 34", dcyc); end
    if (rdy35 !== 1'b1)  begin n_err++; $display("FAIL b2b_ready35: got %b expected 1", rdy35); end
    if (busy36 !== 1'b1) begin n_err++; $display("FAIL b2b_reaccept: got %b expected 1", busy36); end
    if (d != 29)         begin n_err++; $display("FAIL b2b_second_done: got %0d expected 29", d); end
  endtask

  task automatic test_reset_mid();
    int d, b, r;
    issue(OP_MUL, 32'h1234_5678, 32'd9, 32'hA3D7_0A38);
    for (int n = 1; n <= 20; n++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    n_cmp += 4;
    if (ready !== 1'b1)   begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
    if (busy !== 1'b0)    begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (done !== 1'b0)    begin n_err++; $display("FAIL rstmid_done: got %b expected 0", done); end
    if (result !== 32'h0) begin n_err++; $display("FAIL rstmid_result: got %h expected 0", result); end
    issue(OP_MUL, 32'd3, 32'd5, 32'hF);
    observe(40, d, b, r);
    n_cmp++;
    if (d != 34) begin n_err++; $display("FAIL rstmid_mul_done: got %0d expected 34", d); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; last_res = '0;
    test_reset();
    test_mul_timing();
    test_mul_high();
    test_divide();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_results: got %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Iterative multi-cycle multiply/divide sequencer that sits beside the single-cycle ALU in the execute stage.
- Accepts one RV32M operation per start handshake and runs a one-bit-per-cycle shift-add multiply or restoring-divide datapath.
- Holds the pipeline via busy while running, then returns the 32-bit result with a one-cycle done pulse for the ALU_MEM latch.

Parameters:
XLEN, 32, operand and result width
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; accepted only when ready=1
flush  input  1  kill the in-flight operation (branch or exception flush)
op  input  3  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
src1  input  XLEN  forwarded rs1 value, sampled at accept
src2  input  XLEN  forwarded rs2 value, sampled at accept
ready  output  1  unit idle, can accept start
busy  output  1  operation in progress; drives the pipeline stall
done  output  1  one-cycle pulse; result valid in the same cycle
result  output  XLEN  operation result; holds its value until the next done

Behaviour:
- Reset (rst=1 at an edge, from any state): state=IDLE, counter=0, all internal registers 0. Next cycle: ready=1, busy=0, done=0, result=0. Reset takes priority over flush and start.
- States: IDLE, CALC, FIX, DONE.
- Outputs by state: ready=1 only in IDLE. busy=1 in CALC and FIX. done=1 only in DONE.
- Accept: start=1, ready=1, flush=0 at an edge. Call that cycle 0. op, src1 and src2 are latched at that edge.
- Operand prep at accept:
  - Signed operands (MULH, MULHSU rs1 only, DIV, REM) are converted to magnitudes.
  - Result sign flags are recorded.
  - A 2*XLEN product/remainder accumulator is cleared. The counter is cleared.
- Normal path: IDLE -> CALC in cycles 1..32, one bit per cycle. When counter=31, CALC -> FIX. FIX (cycle 33) -> DONE. done=1 in cycle 34, then DONE -> IDLE unconditionally. ready=1 in cycle 35.
- Multiply: shift-add over 32 cycles into a 64-bit accumulator. FIX applies two's-complement negation when the sign flags differ.
  - MUL returns low 32 bits.
  - MULH, MULHSU and MULHU return high 32 bits.
- Divide: restoring, 32 iterations. FIX negates the quotient if the operand signs differ. FIX negates the remainder if the dividend is negative.
- Special cases are detected at accept and bypass CALC and FIX: IDLE -> DONE, done=1 in cycle 1.
  - Divide by zero (src2=0): DIV and DIVU return 0xFFFFFFFF. REM and REMU return src1.
  - Signed overflow (DIV/REM with src1=0x80000000, src2=0xFFFFFFFF): DIV returns 0x80000000. REM returns 0.
- result is written only on entry to DONE and is otherwise held.
- start while ready=0 is ignored, not queued. This includes start during the DONE cycle; accept happens next cycle.
- flush=1 at an edge in CALC, FIX or DONE: state -> IDLE, done never asserts, result is unchanged. If flush hits in DONE, the done pulse already in that cycle stands.
- flush=1 and start=1 in IDLE: flush wins, no accept.
- All arithmetic is modulo 2^XLEN, or 2^(2*XLEN) in the accumulator. There are no exceptions or flags.

Decomposition:
- define.v holds:
  - the op funct3 macros: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111;
  - the state encodings (IDLE 00, CALC 01, FIX 10, DONE 11);
  - XLEN and the MulDivOpBus width macro.
- One sub-module, muldiv_step. It is combinational and implements one iteration: conditional add-and-shift for multiply, trial-subtract-and-shift for divide. It is selected by a mode bit and instantiated once.

Test Plan:
1. MUL src1=7, src2=0xFFFFFFFD -> result 0xFFFFFFEB. done=1 exactly in cycle 34. busy=1 in cycles 1..33. ready=1 in cycle 35.
2. src1=src2=0xFFFFFFFF: MULHU -> 0xFFFFFFFE, MULH -> 0x00000000, MULHSU -> 0xFFFFFFFF, MUL -> 0x00000001.
3. Divide and remainder: DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, DIVU 100/7 -> 0x0000000E, REMU 100/7 -> 0x00000002. Each has done in cycle 34.
4. Special cases, each with done in cycle 1 and busy never high:
   - DIVU 0x1234/0 -> 0xFFFFFFFF.
   - REM 0x1234/0 -> 0x00001234.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM 0x80000000/0xFFFFFFFF -> 0.
5. Flush and handshake:
   - flush pulsed in cycle 10 of a DIVU -> no done, ready=1 in cycle 11, result keeps its old value.
   - start held high for 40 cycles -> exactly one done in cycle 34 and re-accept in cycle 35.
6. rst asserted in cycle 20 of a MUL -> next cycle ready=1, busy=0, done=0, result=0. A new MUL 3*5 then returns 0x0000000F.
